// File: rtl/quad_step_decoder.sv
// Quadrature encoder front-end: sync, per-channel glitch filter, step/direction decode.
// Optional QUAD_ERR_COUNT_EN adds a saturating count of illegal transitions.
module quad_step_decoder #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chan_a,
  input  logic       chan_b,
`ifdef QUAD_ERR_COUNT_EN
  input  logic       err_clr,
  output logic [7:0] err_count,
`endif
  output logic       step,
  output logic       up_dwbar,
  output logic       err
);

  localparam logic [7:0] CNT_LAST = 8'(FILT_LEN - 1);

  typedef enum logic [0:0] {ST_INIT, ST_TRACK} state_e;

  state_e     state_q, state_d;
  logic [1:0] init_cnt_q, init_cnt_d;

  // Bit 1 carries phase A, bit 0 carries phase B throughout.
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] filt_q, filt_d;
  logic [1:0] prev_q, prev_d;
  logic [7:0] cnt_q [2];
  logic [7:0] cnt_d [2];
  logic       step_q, step_d;
  logic       err_q, err_d;
  logic       up_q, up_d;

  // Gray-code phase to position on the 00->01->11->10 cycle.
  function automatic logic [1:0] phase_pos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 2'd1;
        if (init_cnt_q == 2'd2) state_d = ST_TRACK;
      end
      ST_TRACK: state_d = ST_TRACK;
      default:  state_d = ST_INIT;
    endcase
  end

  always_comb begin
    filt_d = filt_q;
    prev_d = prev_q;
    cnt_d  = cnt_q;
    step_d = 1'b0;
    err_d  = 1'b0;
    up_d   = up_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == CNT_LAST) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = 8'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
    case (state_q)
      ST_INIT: begin
        // Filter is bypassed and prev follows the freshly loaded level, so the
        // first TRACK compare never sees a stale pre-reset phase as a change.
        filt_d = sync2_q;
        prev_d = sync2_q;
        cnt_d  = '{default: 8'd0};
      end
      ST_TRACK: begin
        prev_d = filt_q;
        if (filt_q == ~prev_q) begin
          err_d = 1'b1;
        end else if (filt_q != prev_q) begin
          step_d = 1'b1;
          up_d   = (phase_pos(filt_q) == phase_pos(prev_q) + 2'd1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      filt_q  <= 2'b00;
      prev_q  <= 2'b00;
      cnt_q   <= '{default: 8'd0};
      step_q  <= 1'b0;
      err_q   <= 1'b0;
      up_q    <= 1'b1;
    end else begin
      sync1_q <= {chan_a, chan_b};
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      err_q   <= err_d;
      up_q    <= up_d;
    end
  end

  assign step     = step_q;
  assign err      = err_q;
  assign up_dwbar = up_q;

`ifdef QUAD_ERR_COUNT_EN
  logic [7:0] err_count_q;

  // A clear wins over an err pulse in the same cycle; that pulse is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_count_q <= 8'd0;
    end else if (err_clr) begin
      err_count_q <= 8'd0;
    end else if (err_q && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: random pin stimulus, window-based reference model,
// event scoreboard. Build with QUAD_ERR_COUNT_EN to exercise the error counter.
module tb_quad_step_decoder;

  localparam int FL = 4;
  localparam int W  = 19;  // {cycle[15:0], step, err, up_dwbar}

  logic clk = 1'b0;
  logic reset, chan_a, chan_b;
  logic step, up_dwbar, err;
  logic err_clr;
`ifdef QUAD_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  always #5 clk = ~clk;

  quad_step_decoder #(.FILT_LEN(FL)) dut (
    .clk      (clk),
    .reset    (reset),
    .chan_a   (chan_a),
    .chan_b   (chan_b),
`ifdef QUAD_ERR_COUNT_EN
    .err_clr  (err_clr),
    .err_count(err_count),
`endif
    .step     (step),
    .up_dwbar (up_dwbar),
    .err      (err)
  );

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [1:0] seq_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  // Reference model state
  logic [1:0] ph [0:FL+1];
  logic [1:0] m_filt, m_prev;
  logic       m_up;
  int         init_left;
  int         m_errcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int pos(input logic [1:0] v);
    int p = 0;
    for (int k = 0; k < 4; k++) if (seq_tab[k] == v) p = k;
    return p;
  endfunction

  // Model: a channel adopts a level once the synchronised input has shown it
  // for FL consecutive cycles; steps/errors come from the phase distance.
  task automatic model_step();
    logic [1:0] smp;
    logic [1:0] cur;
    int dp;
    smp = reset ? {chan_a, chan_b} : 2'b00;
    for (int j = FL + 1; j > 0; j--) ph[j] = ph[j-1];
    ph[0] = smp;
    cyc++;
    if (!reset) begin
      m_filt = 2'b00; m_prev = 2'b00; m_up = 1'b1; init_left = 3;
    end else if (init_left > 0) begin
      m_filt = ph[2]; m_prev = m_filt; init_left--;
    end else begin
      cur = m_filt;
      if (cur != m_prev) begin
        dp = (pos(cur) - pos(m_prev) + 4) % 4;
        if (dp == 2) begin
          exp_q.push_back({cyc[15:0], 1'b0, 1'b1, m_up});
          if (m_errcnt < 255) m_errcnt++;
        end else begin
          m_up = (dp == 1);
          exp_q.push_back({cyc[15:0], 1'b1, 1'b0, m_up});
        end
      end
      m_prev = cur;
      for (int ch = 0; ch < 2; ch++) begin
        logic same;
        same = 1'b1;
        for (int j = 2; j <= FL + 1; j++) if (ph[j][ch] != ph[2][ch]) same = 1'b0;
        if (same) m_filt[ch] = ph[2][ch];
      end
    end
  endtask

  initial begin
    for (int j = 0; j <= FL + 1; j++) ph[j] = 2'b00;
    m_filt = 2'b00; m_prev = 2'b00; m_up = 1'b1; init_left = 3; m_errcnt = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: pop one expectation per observed event
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (step || err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {cyc[15:0], step, err, up_dwbar}, '0);
        end else begin
          e = exp_q.pop_front();
          check("event", {cyc[15:0], step, err, up_dwbar}, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic hold_pins(input logic [1:0] v, input int n);
    {chan_a, chan_b} = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_quiet(input string name);
    @(negedge clk);
    check(name, {29'd0, step, err, up_dwbar}, 32'b001);
    @(posedge clk); #1;
  endtask

  logic [1:0] pins;
  int t0, lat;
  logic seen;

  initial begin
    reset = 1'b0; chan_a = 1'b0; chan_b = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset_outputs");
    reset = 1'b1;
    check_quiet("init_outputs");
    hold_pins(2'b00, 10);

    // Latency from sampling edge to step
    {chan_a, chan_b} = 2'b01;
    t0 = cyc + 1; lat = -1; seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (step && !seen) begin lat = cyc - t0; seen = 1'b1; end
    end
    check("step_latency", lat, FL + 2);
    @(posedge clk); #1;

    // Forward then reverse sequences
    hold_pins(2'b11, 10); hold_pins(2'b10, 10); hold_pins(2'b00, 10);
    check("fwd_up_level", {31'd0, up_dwbar}, 32'd1);
    hold_pins(2'b10, 10); hold_pins(2'b11, 10); hold_pins(2'b01, 10); hold_pins(2'b00, 10);
    check("rev_up_level", {31'd0, up_dwbar}, 32'd0);

    // Glitch rejection from 01: short and threshold-length A pulses
    hold_pins(2'b01, 10);
    hold_pins(2'b11, FL - 1); hold_pins(2'b01, 12);
    hold_pins(2'b11, FL);     hold_pins(2'b01, 12);

    // Illegal jump then a legal step
    hold_pins(2'b00, 10);
    hold_pins(2'b11, 10);
    hold_pins(2'b10, 10);

    // Reset two cycles after an A edge, pins left at 11
    hold_pins(2'b00, 10); hold_pins(2'b01, 10);
    hold_pins(2'b11, 2);
    reset = 1'b0;
    check_quiet("midreset_outputs");
    reset = 1'b1;
    for (int k = 0; k < 4; k++) check_quiet("reacquire_outputs");
    hold_pins(2'b11, 6);
    hold_pins(2'b10, 10);
    check("after_reacq_up", {31'd0, up_dwbar}, 32'd1);

    // Randomized moves
    pins = 2'b10;
    for (int m = 0; m < 300; m++) begin
      int kind, hold;
      logic [1:0] g;
      kind = $urandom_range(0, 19);
      hold = $urandom_range(1, 3 * FL);
      if (kind < 8) begin
        pins = seq_tab[(pos(pins) + 1) % 4]; hold_pins(pins, hold);
      end else if (kind < 14) begin
        pins = seq_tab[(pos(pins) + 3) % 4]; hold_pins(pins, hold);
      end else if (kind < 16) begin
        pins = ~pins; hold_pins(pins, hold);
      end else if (kind < 19) begin
        g = pins ^ ($urandom_range(0, 1) ? 2'b10 : 2'b01);
        hold_pins(g, $urandom_range(1, FL + 1));
        hold_pins(pins, hold);
      end else begin
        reset = 1'b0;
        hold_pins(pins, $urandom_range(1, 3));
        reset = 1'b1;
        hold_pins(pins, hold);
      end
    end
    hold_pins(pins, 3 * FL);

`ifdef QUAD_ERR_COUNT_EN
    // Saturation then clear coincident with an err pulse
    for (int m = 0; m < 260; m++) begin
      pins = ~pins; hold_pins(pins, FL + 3);
    end
    hold_pins(pins, 4);
    check("err_count_sat", {24'd0, err_count}, 32'd255);
    check("err_count_model", {24'd0, err_count}, m_errcnt);
    err_clr = 1'b1;
    pins = ~pins; hold_pins(pins, FL + 8);
    err_clr = 1'b0;
    hold_pins(pins, 4);
    check("err_count_clr", {24'd0, err_count}, 32'd0);
`endif

    hold_pins(pins, 10);
    check("queue_drained", exp_q.size(), 32'd0);
    check("final_up_level", {31'd0, up_dwbar}, {31'd0, m_up});
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
